multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all encodings SHALL come from the shared package.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 opcode  input  7  instruction[6:0] from the instruction register.
REQ-005 funct3  input  3  instruction[14:12].
REQ-006 funct7_5  input  1  instruction[30].
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  unified-memory completion strobe for the current access.
REQ-009 pc_write  output  1  PC register load enable.
REQ-010 ir_write  output  1  instruction register (and old-PC register) load enable.
REQ-011 adr_src  output  1  memory address select: 0 = PC, 1 = result.
REQ-012 mem_read  output  1  memory read request.
REQ-013 mem_write  output  1  memory write request.
REQ-014 reg_write  output  1  register-file write enable.
REQ-015 alu_src_a  output  2  ALU A operand: 00 = PC, 01 = old PC, 10 = rs1 data.
REQ-016 alu_src_b  output  2  ALU B operand: 00 = rs2 data, 01 = immediate, 10 = constant 4.
REQ-017 result_src  output  2  result select: 00 = ALU-out register, 01 = memory data, 10 = live ALU result.
REQ-018 imm_src  output  3  immediate format: I/S/B/U/J.
REQ-019 alu_ctrl  output  4  ALU operation: ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU/PASS_B.
REQ-020 state_o  output  4  current state, for debug.
REQ-021 illegal  output  1  sticky flag: an unsupported opcode was decoded.

Function
REQ-022 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC and HALT.
REQ-023 FETCH SHALL drive adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, alu_ctrl=ADD and result_src=10.
- The state SHALL be held while mem_ready=0.
- ir_write and pc_write SHALL be 1 only in the mem_ready=1 cycle; the next state SHALL then be DECODE.
REQ-024 DECODE SHALL compute old PC + B-immediate (alu_src_a=01, alu_src_b=01, imm_src=B) and branch on opcode:
- 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH.
- 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC.
- Any other opcode -> HALT, and illegal SHALL be set.
REQ-025 MEMADR SHALL compute rs1 + immediate (S format for stores, I format for loads) and go to MEMREAD for loads or MEMWRITE for stores.
REQ-026 MEMREAD SHALL assert adr_src=1 and mem_read=1, hold until mem_ready, then go to MEMWB.
REQ-027 MEMWRITE SHALL assert adr_src=1 and mem_write=1, hold until mem_ready, then go to FETCH.
REQ-028 MEMWB SHALL assert reg_write=1 with result_src=01, then go to FETCH.
REQ-029 EXECR/EXECI SHALL derive alu_ctrl from funct3 and funct7_5 (SUB only for R-type with funct7_5=1; SRA for funct3=101 with funct7_5=1), then go to ALUWB.
REQ-030 ALUWB SHALL assert reg_write=1 with result_src=00, then go to FETCH.
REQ-031 BRANCH SHALL select alu_src_a=10, alu_src_b=00 and result_src=00 (branch target), and SHALL set alu_ctrl and pc_write from funct3:
- beq/bne: alu_ctrl=SUB; pc_write=zero for beq, ~zero for bne.
- blt/bge: alu_ctrl=SLT; bltu/bgeu: alu_ctrl=SLTU.
- pc_write=~zero for blt/bltu and zero for bge/bgeu.
- The next state SHALL be FETCH.
REQ-032 JAL SHALL assert pc_write (target old PC + J-immediate) and reg_write (link old PC + 4) in one cycle, then go to FETCH; JALR SHALL do the same with target (rs1 + I-immediate) with bit0 cleared.
REQ-033 LUI SHALL write alu_ctrl=PASS_B of the U-immediate; AUIPC SHALL write old PC + U-immediate; both SHALL then go to FETCH.
REQ-034 HALT SHALL be absorbing until rst, with all enables 0.
REQ-035 Outputs SHALL be Moore, except BRANCH pc_write, which depends on zero in that cycle.
REQ-036 Enables not listed for a state SHALL be 0.
REQ-037 mem_read and mem_write SHALL never be asserted together.

Reset
REQ-038 With rst=1 at a clock edge, the state SHALL become FETCH and illegal SHALL clear, regardless of current state or a pending memory access.
REQ-039 While rst=1, all write and request enables SHALL be 0; muxes SHALL take their FETCH values.
REQ-040 Memory requests SHALL restart from FETCH after rst deasserts.

Structure
REQ-041 Package riscv_pkg SHALL hold the state enum, the alu_ctrl, imm_src and mux-select encodings, and the opcode constants.
REQ-042 One sub-module, alu_decoder (funct3, funct7_5, op-class -> alu_ctrl), SHALL be instantiated.

Verification
REQ-043 add x3,x1,x2 with mem_ready tied to 1 -> FETCH, DECODE, EXECR, ALUWB; reg_write=1 only in ALUWB; 4 cycles total.
REQ-044 lw with mem_ready low for 3 cycles in MEMREAD -> state held, mem_read=1 throughout, MEMWB one cycle after mem_ready.
REQ-045 beq with zero=1, then beq with zero=0 -> pc_write=1, then pc_write=0, in BRANCH; bge with zero=1 -> pc_write=1.
REQ-046 Opcode 0000000 -> HALT, illegal=1, no enables for 10 cycles; rst -> FETCH, illegal=0.
REQ-047 rst asserted during MEMWRITE with mem_ready=0 -> next state FETCH and mem_write=0 that cycle.
REQ-048 jalr funct3=000 -> pc_write=1 and reg_write=1 in the same cycle, then FETCH.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings for the multicycle RV32I control path
package riscv_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR     = 4'd11,
    ST_LUI      = 4'd12,
    ST_AUIPC    = 4'd13,
    ST_HALT     = 4'd14
  } state_e;

  typedef enum logic [2:0] {
    ACLS_ADD    = 3'd0,
    ACLS_PASSB  = 3'd1,
    ACLS_BRANCH = 3'd2,
    ACLS_RTYPE  = 3'd3,
    ACLS_ITYPE  = 3'd4
  } alu_class_e;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLL    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_SLT    = 4'd8;
  localparam logic [3:0] ALU_SLTU   = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] imm_src;
  } ctrl_t;

  // Every state starts from the fetch mux setting with all enables dropped.
  localparam ctrl_t CTRL_FETCH_MUX = '{
    pc_write:   1'b0,
    ir_write:   1'b0,
    adr_src:    ADR_PC,
    mem_read:   1'b0,
    mem_write:  1'b0,
    reg_write:  1'b0,
    alu_src_a:  SRCA_PC,
    alu_src_b:  SRCB_FOUR,
    result_src: RES_ALU,
    imm_src:    IMM_I
  };

  function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
    logic taken;
    case (f3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = ~zero;
      3'b101:  taken = zero;
      3'b110:  taken = ~zero;
      3'b111:  taken = zero;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps funct3/funct7_5 and the operation class onto alu_ctrl
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  input  alu_class_e i_alu_class,
  output logic [3:0] o_alu_ctrl
);

  logic [3:0] w_arith;

  // Shared by R and I forms; SUB exists only in the register form.
  always_comb begin
    w_arith = ALU_ADD;
    case (i_funct3)
      3'b000:  w_arith = (i_funct7_5 && (i_alu_class == ACLS_RTYPE)) ? ALU_SUB : ALU_ADD;
      3'b001:  w_arith = ALU_SLL;
      3'b010:  w_arith = ALU_SLT;
      3'b011:  w_arith = ALU_SLTU;
      3'b100:  w_arith = ALU_XOR;
      3'b101:  w_arith = i_funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_arith = ALU_OR;
      3'b111:  w_arith = ALU_AND;
      default: w_arith = ALU_ADD;
    endcase
  end

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_alu_class)
      ACLS_PASSB: o_alu_ctrl = ALU_PASS_B;
      ACLS_BRANCH: begin
        case (i_funct3[2:1])
          2'b10:   o_alu_ctrl = ALU_SLT;
          2'b11:   o_alu_ctrl = ALU_SLTU;
          default: o_alu_ctrl = ALU_SUB;
        endcase
      end
      ACLS_RTYPE, ACLS_ITYPE: o_alu_ctrl = w_arith;
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM for a unified-memory datapath
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [3:0] alu_ctrl,
  output logic [3:0] state_o,
  output logic       illegal
);

  state_e     r_state;
  state_e     w_next;
  logic       r_illegal;
  ctrl_t      w_ctrl;
  alu_class_e w_alu_class;
  logic [3:0] w_alu_ctrl;
  logic       w_is_store;

  assign w_is_store = (opcode == OP_STORE);

  alu_decoder u_alu_decoder (
    .i_funct3    (funct3),
    .i_funct7_5  (funct7_5),
    .i_alu_class (w_alu_class),
    .o_alu_ctrl  (w_alu_ctrl)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: if (mem_ready) w_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_next = ST_MEMADR;
          OP_RTYPE:          w_next = ST_EXECR;
          OP_ITYPE:          w_next = ST_EXECI;
          OP_BRANCH:         w_next = ST_BRANCH;
          OP_JAL:            w_next = ST_JAL;
          OP_JALR:           w_next = ST_JALR;
          OP_LUI:            w_next = ST_LUI;
          OP_AUIPC:          w_next = ST_AUIPC;
          default:           w_next = ST_HALT;
        endcase
      end
      ST_MEMADR:          w_next = w_is_store ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:         if (mem_ready) w_next = ST_MEMWB;
      ST_MEMWRITE:        if (mem_ready) w_next = ST_FETCH;
      ST_EXECR, ST_EXECI: w_next = ST_ALUWB;
      ST_HALT:            w_next = ST_HALT;
      default:            w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_DECODE) && (w_next == ST_HALT)) r_illegal <= 1'b1;
    end
  end

  // Reset forces the fetch mux setting with every enable low.
  always_comb begin
    w_ctrl      = CTRL_FETCH_MUX;
    w_alu_class = ACLS_ADD;
    if (!rst) begin
      case (r_state)
        ST_FETCH: begin
          w_ctrl.mem_read = 1'b1;
          w_ctrl.ir_write = mem_ready;
          w_ctrl.pc_write = mem_ready;
        end
        ST_DECODE: begin
          w_ctrl.alu_src_a = SRCA_OLDPC;
          w_ctrl.alu_src_b = SRCB_IMM;
          w_ctrl.imm_src   = IMM_B;
        end
        ST_MEMADR: begin
          w_ctrl.alu_src_a = SRCA_RS1;
          w_ctrl.alu_src_b = SRCB_IMM;
          w_ctrl.imm_src   = w_is_store ? IMM_S : IMM_I;
        end
        ST_MEMREAD: begin
          w_ctrl.adr_src    = ADR_RESULT;
          w_ctrl.mem_read   = 1'b1;
          w_ctrl.result_src = RES_ALUOUT;
        end
        ST_MEMWB: begin
          w_ctrl.reg_write  = 1'b1;
          w_ctrl.result_src = RES_MEM;
        end
        ST_MEMWRITE: begin
          w_ctrl.adr_src    = ADR_RESULT;
          w_ctrl.mem_write  = 1'b1;
          w_ctrl.result_src = RES_ALUOUT;
        end
        ST_EXECR: begin
          w_ctrl.alu_src_a = SRCA_RS1;
          w_ctrl.alu_src_b = SRCB_RS2;
          w_alu_class      = ACLS_RTYPE;
        end
        ST_EXECI: begin
          w_ctrl.alu_src_a = SRCA_RS1;
          w_ctrl.alu_src_b = SRCB_IMM;
          w_alu_class      = ACLS_ITYPE;
        end
        ST_ALUWB: begin
          w_ctrl.reg_write  = 1'b1;
          w_ctrl.result_src = RES_ALUOUT;
        end
        ST_BRANCH: begin
          w_ctrl.alu_src_a  = SRCA_RS1;
          w_ctrl.alu_src_b  = SRCB_RS2;
          w_ctrl.result_src = RES_ALUOUT;
          w_ctrl.pc_write   = branch_taken(funct3, zero);
          w_alu_class       = ACLS_BRANCH;
        end
        ST_JAL: begin
          w_ctrl.pc_write  = 1'b1;
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_src_a = SRCA_OLDPC;
          w_ctrl.alu_src_b = SRCB_IMM;
          w_ctrl.imm_src   = IMM_J;
        end
        ST_JALR: begin
          w_ctrl.pc_write  = 1'b1;
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_src_a = SRCA_RS1;
          w_ctrl.alu_src_b = SRCB_IMM;
          w_ctrl.imm_src   = IMM_I;
        end
        ST_LUI: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_src_b = SRCB_IMM;
          w_ctrl.imm_src   = IMM_U;
          w_alu_class      = ACLS_PASSB;
        end
        ST_AUIPC: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_src_a = SRCA_OLDPC;
          w_ctrl.alu_src_b = SRCB_IMM;
          w_ctrl.imm_src   = IMM_U;
        end
        default: ;
      endcase
    end
  end

  assign pc_write   = w_ctrl.pc_write;
  assign ir_write   = w_ctrl.ir_write;
  assign adr_src    = w_ctrl.adr_src;
  assign mem_read   = w_ctrl.mem_read;
  assign mem_write  = w_ctrl.mem_write;
  assign reg_write  = w_ctrl.reg_write;
  assign alu_src_a  = w_ctrl.alu_src_a;
  assign alu_src_b  = w_ctrl.alu_src_b;
  assign result_src = w_ctrl.result_src;
  assign imm_src    = w_ctrl.imm_src;
  assign alu_ctrl   = w_alu_ctrl;
  assign state_o    = r_state;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized bench for multicycle_ctrl against a step-plan model
module tb_multicycle_ctrl;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl, state_o;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .alu_ctrl(alu_ctrl), .state_o(state_o), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct { state_e st; bit waits; } step_t;

  localparam logic [12:0] C_A = 13'h1800;
  localparam logic [12:0] C_B = 13'h0600;
  localparam logic [12:0] C_R = 13'h0180;
  localparam logic [12:0] C_I = 13'h0070;
  localparam logic [12:0] C_C = 13'h000F;

  step_t plan_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    m_illegal = 1'b0;
  int    f_ready = -1, f_zero = -1;
  int    next_cls = -1, next_f3 = -1, next_f7 = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] mx(input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] r, input logic [2:0] i,
                                     input logic [3:0] c);
    return {a, b, r, i, c};
  endfunction

  function automatic logic [3:0] exp_alu(input bit rtype);
    logic [3:0] tbl [8];
    logic [3:0] v;
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    v = tbl[funct3];
    if (funct7_5 && funct3 == 3'b101) v = ALU_SRA;
    if (funct7_5 && funct3 == 3'b000 && rtype) v = ALU_SUB;
    return v;
  endfunction

  function automatic void push(input state_e st, input bit w);
    plan_q.push_back(step_t'{st, w});
  endfunction

  // Pick the next instruction and lay out the state walk it must take.
  function automatic void new_instr();
    int cls;
    logic [2:0] br_f3 [6];
    br_f3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    cls = (next_cls >= 0) ? next_cls : int'($urandom_range(0, 8));
    funct3 = 3'($urandom_range(0, 7));
    funct7_5 = 1'b0;
    plan_q.delete();
    push(ST_FETCH, 1'b1);
    push(ST_DECODE, 1'b0);
    case (cls)
      0: begin opcode = 7'b0000011; push(ST_MEMADR, 0); push(ST_MEMREAD, 1); push(ST_MEMWB, 0); end
      1: begin opcode = 7'b0100011; push(ST_MEMADR, 0); push(ST_MEMWRITE, 1); end
      2, 3: begin
        opcode = (cls == 2) ? 7'b0110011 : 7'b0010011;
        if (funct3 == 3'b000 || funct3 == 3'b101) funct7_5 = 1'($urandom_range(0, 1));
        push((cls == 2) ? ST_EXECR : ST_EXECI, 0);
        push(ST_ALUWB, 0);
      end
      4: begin opcode = 7'b1100011; funct3 = br_f3[$urandom_range(0, 5)]; push(ST_BRANCH, 0); end
      5: begin opcode = 7'b1101111; push(ST_JAL, 0); end
      6: begin opcode = 7'b1100111; funct3 = 3'b000; push(ST_JALR, 0); end
      7: begin opcode = 7'b0110111; push(ST_LUI, 0); end
      8: begin opcode = 7'b0010111; push(ST_AUIPC, 0); end
      default: begin opcode = 7'b0000000; push(ST_HALT, 0); end
    endcase
    if (next_f3 >= 0) funct3 = 3'(next_f3);
    if (next_f7 >= 0) funct7_5 = 1'(next_f7);
    next_cls = -1;
    next_f3 = -1;
    next_f7 = -1;
  endfunction

  // en order: {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write}
  function automatic void expect_out(input state_e st, output logic [5:0] en,
                                     output logic [12:0] mx_e, output logic [12:0] care);
    logic taken;
    logic [3:0] br_alu;
    en = 6'b0; mx_e = 13'b0; care = 13'b0;
    taken = (funct3 == 3'b000 || funct3 == 3'b101 || funct3 == 3'b111) ? zero : !zero;
    br_alu = !funct3[2] ? ALU_SUB : (!funct3[1] ? ALU_SLT : ALU_SLTU);
    case (st)
      ST_FETCH: begin
        en = {mem_ready, mem_ready, 1'b0, 1'b1, 1'b0, 1'b0};
        mx_e = mx(2'b00, 2'b10, 2'b10, IMM_I, ALU_ADD); care = C_A | C_B | C_R | C_C;
      end
      ST_DECODE:   begin mx_e = mx(2'b01, 2'b01, 2'b00, IMM_B, ALU_ADD); care = C_A | C_B | C_I | C_C; end
      ST_MEMADR:   begin
        mx_e = mx(2'b10, 2'b01, 2'b00, (opcode == 7'b0100011) ? IMM_S : IMM_I, ALU_ADD);
        care = C_A | C_B | C_I | C_C;
      end
      ST_MEMREAD:  en = 6'b001100;
      ST_MEMWRITE: en = 6'b001010;
      ST_MEMWB:    begin en = 6'b000001; mx_e = mx(2'b00, 2'b00, 2'b01, IMM_I, 4'd0); care = C_R; end
      ST_EXECR:    begin mx_e = mx(2'b00, 2'b00, 2'b00, IMM_I, exp_alu(1'b1)); care = C_C; end
      ST_EXECI:    begin mx_e = mx(2'b00, 2'b00, 2'b00, IMM_I, exp_alu(1'b0)); care = C_C; end
      ST_ALUWB:    begin en = 6'b000001; care = C_R; end
      ST_BRANCH:   begin
        en = {taken, 5'b0};
        mx_e = mx(2'b10, 2'b00, 2'b00, IMM_I, br_alu); care = C_A | C_B | C_R | C_C;
      end
      ST_JAL, ST_JALR: en = 6'b100001;
      ST_LUI:      begin en = 6'b000001; mx_e = mx(2'b00, 2'b00, 2'b00, IMM_U, ALU_PASS_B); care = C_I | C_C; end
      ST_AUIPC:    begin
        en = 6'b000001; mx_e = mx(2'b01, 2'b01, 2'b00, IMM_U, ALU_ADD);
        care = C_A | C_B | C_I | C_C;
      end
      default: ;
    endcase
  endfunction

  task automatic drive_random();
    mem_ready = (f_ready < 0) ? 1'($urandom_range(0, 1)) : 1'(f_ready);
    zero      = (f_zero < 0) ? 1'($urandom_range(0, 1)) : 1'(f_zero);
  endtask

  task automatic cycle();
    logic [5:0]  en_e;
    logic [12:0] mx_e, care, mx_o;
    step_t cur;
    cur = plan_q[0];
    drive_random();
    #4;
    expect_out(cur.st, en_e, mx_e, care);
    mx_o = {alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl};
    chk($sformatf("state/%s", cur.st.name()), state_o, cur.st);
    chk($sformatf("enables/%s", cur.st.name()),
        {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write}, en_e);
    chk($sformatf("muxes/%s", cur.st.name()), mx_o & care, mx_e & care);
    chk("illegal", illegal, m_illegal);
    @(posedge clk); #1;
    if (cur.st != ST_HALT && !(cur.waits && !mem_ready)) begin
      void'(plan_q.pop_front());
      if (plan_q.size() == 0) new_instr();
      else if (plan_q[0].st == ST_HALT) m_illegal = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive_random();
      #4;
      chk("rst_enables", {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write}, 6'b0);
      chk("rst_muxes", {alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl} & (C_A | C_B | C_R | C_C),
          mx(2'b00, 2'b10, 2'b10, IMM_I, ALU_ADD) & (C_A | C_B | C_R | C_C));
      if (i > 0) chk("rst_state", state_o, ST_FETCH);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    m_illegal = 1'b0;
    new_instr();
  endtask

  initial begin
    @(posedge clk); #1;

    // add x3,x1,x2 with memory always ready
    next_cls = 2; next_f3 = 0; next_f7 = 0; f_ready = 1;
    do_reset(3);
    repeat (5) cycle();

    // lw with three stalled cycles in MEMREAD
    next_cls = 0; do_reset(1);
    repeat (3) cycle();
    f_ready = 0; repeat (3) cycle();
    f_ready = 1; repeat (3) cycle();

    // beq taken, beq not taken, bge taken
    next_cls = 4; next_f3 = 0; f_zero = 1; do_reset(1); repeat (3) cycle();
    next_cls = 4; next_f3 = 0; f_zero = 0; do_reset(1); repeat (3) cycle();
    next_cls = 4; next_f3 = 5; f_zero = 1; do_reset(1); repeat (3) cycle();
    f_zero = -1;

    // jalr
    next_cls = 6; do_reset(1); repeat (4) cycle();

    // reset in the middle of a stalled store
    next_cls = 1; do_reset(1); repeat (3) cycle();
    f_ready = 0; cycle();
    do_reset(1);
    repeat (2) cycle();

    // illegal opcode parks in HALT until reset
    next_cls = 9; f_ready = -1; do_reset(1);
    for (int i = 0; i < 60 && plan_q[0].st != ST_HALT; i++) cycle();
    repeat (10) cycle();
    do_reset(2);
    repeat (2) cycle();

    // random instruction stream with random memory stalls and zero flag
    do_reset(1);
    repeat (1500) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
